// File: rtl/f_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: next-PC encodings, memory window
// constants and the F/D pipeline payload.
package f_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;
    localparam logic [XLEN-1:0] IM_BASE  = 32'h0000_3000;
    localparam logic [XLEN-1:0] IM_LAST  = 32'h0000_6FFC;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] adder;
        logic            exc_adel;
    } fd_t;

    // Fetch-address error: misaligned word or outside the instruction window.
    function automatic logic addr_err(
        input logic [XLEN-1:0] addr,
        input logic [XLEN-1:0] base,
        input logic [XLEN-1:0] last
    );
        return (addr[1:0] != 2'b00) || (addr < base) || (addr > last);
    endfunction

endpackage

// File: rtl/f_fetch_unit_f_d_reg.sv
// F/D pipeline register with reset > clear > stall > load priority.
// A clear keeps the PC bookkeeping of the slot but turns the word into a bubble.
module f_d_reg
    import f_fetch_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic stall,
    input  fd_t  d,
    output fd_t  q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q.instr    <= NOP;
            q.pc       <= d.pc;
            q.adder    <= d.adder;
            q.exc_adel <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: PC register, next-PC selection, fetch-window check and the
// F/D register feeding decode. Redirects from D apply after the delay slot.
module f_fetch_unit #(
    parameter logic [31:0] PC_RESET = f_fetch_unit_pkg::PC_RESET,
    parameter logic [31:0] IM_BASE  = f_fetch_unit_pkg::IM_BASE,
    parameter logic [31:0] IM_LAST  = f_fetch_unit_pkg::IM_LAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        D_clr,
    input  logic [1:0]  D_npc_sel,
    input  logic [31:0] D_imm16_EXT,
    input  logic [31:0] D_imm26_EXT,
    input  logic [31:0] D_rs_fwd,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_adder,
    output logic        D_exc_adel
);

    logic [31:0]            F_pc;
    logic [31:0]            F_pc4;
    logic [31:0]            npc;
    logic                   F_adel;
    f_fetch_unit_pkg::fd_t  fd_d;
    f_fetch_unit_pkg::fd_t  fd_q;

    assign F_pc4  = F_pc + 32'd4;
    assign F_adel = f_fetch_unit_pkg::addr_err(F_pc, IM_BASE, IM_LAST);

    // Next-PC source chosen by the instruction currently in decode.
    always_comb begin
        npc = F_pc4;
        case (f_fetch_unit_pkg::npc_sel_e'(D_npc_sel))
            f_fetch_unit_pkg::NPC_PC4: npc = F_pc4;
            f_fetch_unit_pkg::NPC_BR:  npc = D_imm16_EXT;
            f_fetch_unit_pkg::NPC_J:   npc = D_imm26_EXT;
            f_fetch_unit_pkg::NPC_JR:  npc = D_rs_fwd;
            default:                   npc = F_pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc <= PC_RESET;
        end else if (!stall) begin
            F_pc <= npc;
        end
    end

    // An illegal fetch address never lets memory data into the pipe.
    always_comb begin
        fd_d          = '0;
        fd_d.instr    = F_adel ? f_fetch_unit_pkg::NOP : i_inst_rdata;
        fd_d.pc       = F_pc;
        fd_d.adder    = F_pc4;
        fd_d.exc_adel = F_adel;
    end

    f_d_reg u_f_d_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (D_clr),
        .stall (stall),
        .d     (fd_d),
        .q     (fd_q)
    );

    assign i_inst_addr = F_pc;
    assign D_instr     = fd_q.instr;
    assign D_pc        = fd_q.pc;
    assign D_adder     = fd_q.adder;
    assign D_exc_adel  = fd_q.exc_adel;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit with a combinational instruction memory model.
module tb_f_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        D_clr;
    logic [1:0]  D_npc_sel;
    logic [31:0] D_imm16_EXT;
    logic [31:0] D_imm26_EXT;
    logic [31:0] D_rs_fwd;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_adder;
    logic        D_exc_adel;

    int vectors;
    int miscompares;

    f_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .D_clr        (D_clr),
        .D_npc_sel    (D_npc_sel),
        .D_imm16_EXT  (D_imm16_EXT),
        .D_imm26_EXT  (D_imm26_EXT),
        .D_rs_fwd     (D_rs_fwd),
        .i_inst_rdata (i_inst_rdata),
        .i_inst_addr  (i_inst_addr),
        .D_instr      (D_instr),
        .D_pc         (D_pc),
        .D_adder      (D_adder),
        .D_exc_adel   (D_exc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign i_inst_rdata = mem_word(i_inst_addr);

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] adder, input logic adel);
        chk({tag, ".instr"}, D_instr, instr);
        chk({tag, ".pc"}, D_pc, pc);
        chk({tag, ".adder"}, D_adder, adder);
        chk({tag, ".adel"}, 32'(D_exc_adel), 32'(adel));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        D_clr       = 1'b0;
        D_npc_sel   = 2'd0;
        D_imm16_EXT = 32'h0;
        D_imm26_EXT = 32'h0;
        D_rs_fwd    = 32'h0;

        step();
        chk("rst.addr", i_inst_addr, 32'h3000);
        chk_d("rst", 32'h0, 32'h0, 32'h0, 1'b0);

        // Sequential fetch
        reset = 1'b0;
        chk("seq0.addr", i_inst_addr, 32'h3000);
        step();
        chk("seq1.addr", i_inst_addr, 32'h3004);
        chk_d("seq1", mem_word(32'h3000), 32'h3000, 32'h3004, 1'b0);
        step();
        chk("seq2.addr", i_inst_addr, 32'h3008);
        chk_d("seq2", mem_word(32'h3004), 32'h3004, 32'h3008, 1'b0);

        // Branch resolved in D; delay slot at 3008 still enters D
        D_npc_sel   = 2'd1;
        D_imm16_EXT = 32'h3040;
        step();
        chk("br.addr", i_inst_addr, 32'h3040);
        chk_d("br.slot", mem_word(32'h3008), 32'h3008, 32'h300C, 1'b0);
        D_npc_sel = 2'd0;
        step();
        chk("br2.addr", i_inst_addr, 32'h3044);
        chk_d("br2", mem_word(32'h3040), 32'h3040, 32'h3044, 1'b0);

        // Jump presented during a two-cycle stall
        stall       = 1'b1;
        D_npc_sel   = 2'd2;
        D_imm26_EXT = 32'h3100;
        step();
        chk("st1.addr", i_inst_addr, 32'h3044);
        chk_d("st1", mem_word(32'h3040), 32'h3040, 32'h3044, 1'b0);
        step();
        chk("st2.addr", i_inst_addr, 32'h3044);
        chk_d("st2", mem_word(32'h3040), 32'h3040, 32'h3044, 1'b0);
        stall = 1'b0;
        step();
        chk("j.addr", i_inst_addr, 32'h3100);
        chk_d("j", mem_word(32'h3044), 32'h3044, 32'h3048, 1'b0);
        D_npc_sel = 2'd0;

        // Misaligned jr target
        D_npc_sel = 2'd3;
        D_rs_fwd  = 32'h3002;
        step();
        chk("jr.mis.addr", i_inst_addr, 32'h3002);
        D_npc_sel = 2'd0;
        step();
        chk_d("jr.mis", 32'h0, 32'h3002, 32'h3006, 1'b1);
        chk("jr.mis.next", i_inst_addr, 32'h3006);

        // Below the window
        D_npc_sel = 2'd3;
        D_rs_fwd  = 32'h2FFC;
        step();
        chk("jr.lo.addr", i_inst_addr, 32'h2FFC);
        D_npc_sel = 2'd0;
        step();
        chk_d("jr.lo", 32'h0, 32'h2FFC, 32'h3000, 1'b1);

        // Above the window
        D_npc_sel = 2'd3;
        D_rs_fwd  = 32'h7000;
        step();
        D_npc_sel = 2'd0;
        step();
        chk_d("jr.hi", 32'h0, 32'h7000, 32'h7004, 1'b1);

        // Last legal word
        D_npc_sel = 2'd3;
        D_rs_fwd  = 32'h6FFC;
        step();
        D_npc_sel = 2'd0;
        step();
        chk_d("jr.last", mem_word(32'h6FFC), 32'h6FFC, 32'h7000, 1'b0);

        // Lowest legal word
        D_npc_sel = 2'd3;
        D_rs_fwd  = 32'h3000;
        step();
        D_npc_sel = 2'd0;
        step();
        chk_d("jr.base", mem_word(32'h3000), 32'h3000, 32'h3004, 1'b0);

        // Flush with stall at 3010: bubble inserted, PC held
        D_npc_sel = 2'd3;
        D_rs_fwd  = 32'h3010;
        step();
        D_npc_sel = 2'd0;
        stall     = 1'b1;
        D_clr     = 1'b1;
        step();
        chk("clr.addr", i_inst_addr, 32'h3010);
        chk_d("clr", 32'h0, 32'h3010, 32'h3014, 1'b0);
        stall = 1'b0;
        D_clr = 1'b0;
        step();
        chk("clr2.addr", i_inst_addr, 32'h3014);
        chk_d("clr2", mem_word(32'h3010), 32'h3010, 32'h3014, 1'b0);

        // Flush without stall: PC keeps advancing
        D_clr = 1'b1;
        step();
        chk("clr3.addr", i_inst_addr, 32'h3018);
        chk_d("clr3", 32'h0, 32'h3014, 32'h3018, 1'b0);
        D_clr = 1'b0;

        // Reset overrides stall and pending jr
        stall     = 1'b1;
        D_npc_sel = 2'd3;
        D_rs_fwd  = 32'h5000;
        reset     = 1'b1;
        step();
        chk("rst2.addr", i_inst_addr, 32'h3000);
        chk_d("rst2", 32'h0, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
